// File: rtl/pc_sequencer.sv
// Instruction-fetch sequencer: owns the PC, drives the imem request and hands words to decode.
// Define DELAY_SLOT_EN to deliver the MIPS delay-slot word after a redirect instead of squashing it.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redir_valid,
    input  logic [5:0]  redir_op,
    input  logic [31:0] redir_data,
    input  logic [31:0] redir_base,
    output logic [31:0] link_pc
);

`ifdef DELAY_SLOT_EN
    localparam bit SLOT = 1'b1;
`else
    localparam bit SLOT = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pend_tgt;
    logic        pend;
    logic [31:0] nb;
    logic [31:0] tgt;
    logic [31:0] eff_tgt;
    logic        accept;
    logic        eff_valid;
    logic        ack_fire;
    logic        rel;
    logic        squash;
    logic        take;

    always_comb begin
        nb = redir_base + 32'd4;
        case (redir_op)
            6'b000000:            tgt = {redir_data[31:2], 2'b00};
            6'b000010, 6'b000011: tgt = {nb[31:28], redir_data[25:0], 2'b00};
            default:              tgt = nb + {redir_data[29:0], 2'b00};
        endcase
    end

    // A redirect arriving this cycle acts exactly like one already pending.
    assign accept    = redir_valid && !pend && (state != IDLE);
    assign eff_valid = pend || accept;
    assign eff_tgt   = pend ? pend_tgt : tgt;
    assign ack_fire  = (state == FETCH) && imem_ack;
    assign rel       = (state == HOLD) && instr_ready;
    assign squash    = !SLOT && eff_valid;
    assign take      = eff_valid && (ack_fire || (!SLOT && rel));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = FETCH;
            FETCH: if (imem_ack) state_nxt = squash ? FETCH : HOLD;
            HOLD:  if (instr_ready) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_req    = 1'b0;
        imem_addr   = 32'd0;
        instr_valid = 1'b0;
        case (state)
            FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pc;
            end
            HOLD:    instr_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            pend     <= 1'b0;
            pend_tgt <= 32'd0;
            instr    <= 32'd0;
            instr_pc <= 32'd0;
            link_pc  <= 32'd0;
        end else begin
            if (ack_fire && !squash) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
            end
            if (take)          pc <= eff_tgt;
            else if (ack_fire) pc <= pc + 32'd4;
            if (take) begin
                pend <= 1'b0;
            end else if (accept) begin
                pend     <= 1'b1;
                pend_tgt <= tgt;
            end
            if (accept && redir_op == 6'b000011)
                link_pc <= redir_base + 32'd8;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Cycle-table bench for pc_sequencer: sequential fetch, backpressure, redirects, async reset.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redir_valid;
    logic [5:0]  redir_op;
    logic [31:0] redir_data;
    logic [31:0] redir_base;
    logic [31:0] link_pc;

    localparam logic [31:0] TAG = 32'hDEAD_0000;

    always #5 clk = ~clk;

    // Memory returns a word tagged with its own address.
    assign imem_rdata = imem_addr ^ TAG;

    pc_sequencer dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .redir_valid(redir_valid),
        .redir_op(redir_op),
        .redir_data(redir_data),
        .redir_base(redir_base),
        .link_pc(link_pc)
    );

    typedef struct {
        bit          ack;
        bit          rdy;
        bit          rv;
        logic [5:0]  op;
        logic [31:0] data;
        logic [31:0] base;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_val;
        logic [31:0] e_pc;
        logic [31:0] e_link;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] lk;
    int          vecs;
    int          errs;

    function automatic void add(bit a, bit r, bit rv, logic [5:0] op,
                                logic [31:0] d, logic [31:0] b, bit ereq,
                                logic [31:0] eaddr, bit ev, logic [31:0] epc);
        vec_t v;
        v.ack = a; v.rdy = r; v.rv = rv; v.op = op; v.data = d; v.base = b;
        v.e_req = ereq; v.e_addr = eaddr; v.e_val = ev; v.e_pc = epc;
        v.e_link = lk;
        tbl.push_back(v);
    endfunction

    function automatic void fr(logic [31:0] addr, bit a);
        add(a, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 1'b1, addr, 1'b0, 32'd0);
    endfunction

    function automatic void hr(logic [31:0] pc, bit r);
        add(1'b0, r, 1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, pc);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        imem_ack = 1'b0; instr_ready = 1'b0; redir_valid = 1'b0;
        redir_op = 6'd0; redir_data = 32'd0; redir_base = 32'd0;
    endtask

    initial begin
        vecs = 0; errs = 0; lk = 32'd0;
        rst_n = 1'b0;
        idle_in();

        // Reset release, sequential fetch, 5-cycle backpressure.
        add(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        fr(32'h3000, 0); fr(32'h3000, 1); hr(32'h3000, 1);
        fr(32'h3004, 0); fr(32'h3004, 1); hr(32'h3004, 1);
        fr(32'h3008, 0); fr(32'h3008, 1);
        for (int k = 0; k < 5; k++) hr(32'h3008, 0);
        hr(32'h3008, 1);
        fr(32'h300C, 0); fr(32'h300C, 1); hr(32'h300C, 1);
        fr(32'h3010, 0); fr(32'h3010, 1); hr(32'h3010, 1);
        // J from 0x3010 while 0x3014 is outstanding.
        add(1'b0, 1'b0, 1'b1, 6'b000010, 32'h0000_0100, 32'h3010,
            1'b1, 32'h3014, 1'b0, 32'd0);
        fr(32'h3014, 1);
`ifdef DELAY_SLOT_EN
        hr(32'h3014, 1);
`endif
        fr(32'h0400, 0); fr(32'h0400, 1); hr(32'h0400, 1);
        fr(32'h0404, 0);
        // JAL from 0x3020 arriving with the ack of 0x404.
        add(1'b1, 1'b0, 1'b1, 6'b000011, 32'h0000_0C10, 32'h3020,
            1'b1, 32'h0404, 1'b0, 32'd0);
        lk = 32'h3028;
`ifdef DELAY_SLOT_EN
        hr(32'h0404, 1);
`endif
        fr(32'h3040, 0); fr(32'h3040, 1);
        // Branch -4 from 0x3040 while held, then an ignored second J.
        add(1'b0, 1'b0, 1'b1, 6'b000100, 32'hFFFF_FFFC, 32'h3040,
            1'b0, 32'd0, 1'b1, 32'h3040);
        add(1'b0, 1'b0, 1'b1, 6'b000010, 32'h0000_0100, 32'h0000,
            1'b0, 32'd0, 1'b1, 32'h3040);
        hr(32'h3040, 1);
`ifdef DELAY_SLOT_EN
        fr(32'h3044, 0); fr(32'h3044, 1); hr(32'h3044, 1);
`endif
        fr(32'h3034, 0); fr(32'h3034, 1); hr(32'h3034, 1);
        fr(32'h3038, 0);

        repeat (3) @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_link", link_pc, 32'd0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            vec_t v;
            bit   bad;
            v = tbl[i];
            imem_ack    = v.ack;
            instr_ready = v.rdy;
            redir_valid = v.rv;
            redir_op    = v.op;
            redir_data  = v.data;
            redir_base  = v.base;
            bad = (imem_req !== v.e_req)
               || (v.e_req && imem_addr !== v.e_addr)
               || (instr_valid !== v.e_val)
               || (v.e_val && instr_pc !== v.e_pc)
               || (v.e_val && instr !== (v.e_pc ^ TAG))
               || (link_pc !== v.e_link);
            vecs++;
            if (bad) begin
                errs++;
                $display("FAIL row %0d: got req=%b addr=%h val=%b pc=%h instr=%h link=%h want req=%b addr=%h val=%b pc=%h link=%h",
                         i, imem_req, imem_addr, instr_valid, instr_pc, instr,
                         link_pc, v.e_req, v.e_addr, v.e_val, v.e_pc, v.e_link);
            end
            @(negedge clk);
        end

        // Asynchronous reset while a request is outstanding.
        idle_in();
        chk("mid_req", {31'd0, imem_req}, 32'd1);
        chk("mid_addr", imem_addr, 32'h3038);
        rst_n = 1'b0;
        #1;
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk("arst_addr", imem_addr, 32'd0);
        chk("arst_valid", {31'd0, instr_valid}, 32'd0);
        chk("arst_instr", instr, 32'd0);
        chk("arst_instr_pc", instr_pc, 32'd0);
        chk("arst_link", link_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_req", {31'd0, imem_req}, 32'd1);
        chk("restart_addr", imem_addr, 32'h3000);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
